// File: rtl/uart_rx_byte.sv
// uart_rx_byte
//   UART receiver for 8N1 serial traffic. It brings the asynchronous rxd line
//   into the clk domain, finds the start bit, samples each bit near its centre
//   and hands the finished byte to a consumer through a one-entry holding
//   register with a valid/ready handshake.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (>= 4)
//   SYNC_STAGES   flops in the rxd synchroniser (>= 2)
//
// Ports
//   clk        core clock, rising edge
//   rst_n      synchronous active-low reset
//   rxd        asynchronous serial input, idle high
//   rx_data    received byte, LSB is the first data bit on the line
//   rx_valid   rx_data holds a byte that has not been accepted yet
//   rx_ready   consumer accepts the byte when rx_valid is also high
//   frame_err  one-cycle pulse, stop bit was sampled low
//   overrun    one-cycle pulse, a byte was dropped because rx_data was full
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 87,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_done;

  logic [7:0] data_d;
  logic       valid_d;
  logic       ferr_d;
  logic       ovr_d;

  // Synchroniser chain. It resets to the idle (high) line level so that a
  // reset can never be mistaken for a start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
    end
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  // Receiver state: FSM state, bit-time counter, bit index, shift register
  // and the registered outputs all update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      rx_data   <= data_d;
      rx_valid  <= valid_d;
      frame_err <= ferr_d;
      overrun   <= ovr_d;
    end
  end

  // Frame sequencing. The start bit is timed to its centre with a half-bit
  // count, after which every bit (data and stop) is sampled one full bit
  // period later, keeping all sample points near the bit centres.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          state_d = ST_START;
          cnt_d   = HALF_M1;
        end
      end

      ST_START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (rxs) begin
          // Line went back high before the start-bit centre: a glitch.
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DATA;
          cnt_d   = BIT_M1;
          idx_d   = '0;
        end
      end

      ST_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          shift_d[idx_q] = rxs;
          cnt_d          = BIT_M1;
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      ST_STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (rxs) begin
          byte_done = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          ferr_d  = 1'b1;
          state_d = ST_BREAK;
        end
      end

      ST_BREAK: begin
        // A line held low (break) reports one framing error, then waits here
        // until the line returns to idle.
        if (rxs) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Holding register hand-off. A completed byte may replace a byte that is
  // being accepted in the same cycle; if the old byte is not accepted the new
  // one is dropped and reported as an overrun.
  always_comb begin
    data_d  = rx_data;
    valid_d = rx_valid;
    ovr_d   = 1'b0;

    if (byte_done) begin
      if (!rx_valid || rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (rx_valid && rx_ready) begin
      valid_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte
//   Self-checking bench for uart_rx_byte with CLKS_PER_BIT = 8. Frames are
//   driven bit by bit onto rxd; bytes that should be delivered are queued and
//   compared when the DUT hands them over. Flag pulses are counted by a
//   negedge monitor and compared per test.
module tb_uart_rx_byte;

  localparam int BIT_CLKS = 8;

  logic       clk;
  logic       rst_n;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  int errors = 0;
  int checks = 0;

  int xfer_count = 0;
  int ferr_count = 0;
  int ovr_count  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         hold_low;
    int         exp_xfers;
    int         exp_ferr;
    int         exp_ovr;
  } vec_t;

  vec_t vecs[6];

  uart_rx_byte #(
    .CLKS_PER_BIT(BIT_CLKS),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Negedge monitor: scoreboards every handshake and counts flag cycles.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && rx_ready) begin
        checks++;
        xfer_count++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_xfer: got %02h, required no transfer", rx_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (rx_data !== mon_exp) begin
            errors++;
            $display("[TB] FAIL rx_data: got %02h, required %02h", rx_data, mon_exp);
          end
        end
      end
      if (frame_err === 1'b1) ferr_count++;
      if (overrun === 1'b1) ovr_count++;
      if (frame_err === 1'b1 || overrun === 1'b1) begin
        checks++;
        if (frame_err === 1'b1 && overrun === 1'b1) begin
          errors++;
          $display("[TB] FAIL flags_exclusive: got frame_err=1 overrun=1, required not both");
        end
      end
    end
  end

  // Advance n clocks, landing just after a rising edge.
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  // Drive one 8N1 frame; a low stop bit is held low for hold_low more clocks
  // before the line is released.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input int hold_low);
    rxd = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      wait_clks(BIT_CLKS);
    end
    rxd = stop_bit;
    wait_clks(BIT_CLKS);
    if (!stop_bit) begin
      wait_clks(hold_low);
    end
    rxd = 1'b1;
  endtask

  initial begin
    int x0, f0, o0;
    logic [7:0] frame6;

    vecs[0] = '{8'hA5, 1'b1, 0,  1, 0, 0};
    vecs[1] = '{8'h3C, 1'b0, 40, 0, 1, 0};
    vecs[2] = '{8'h11, 1'b1, 0,  1, 0, 0};
    vecs[3] = '{8'hC3, 1'b1, 0,  1, 0, 0};
    vecs[4] = '{8'h80, 1'b1, 0,  1, 0, 0};
    vecs[5] = '{8'h01, 1'b0, 0,  0, 1, 0};

    rst_n    = 1'b0;
    rxd      = 1'b1;
    rx_ready = 1'b1;
    wait_clks(3);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_rx_data", int'(rx_data), 0);
    checkOutput("reset_rx_valid", int'(rx_valid), 0);
    checkOutput("reset_frame_err", int'(frame_err), 0);
    checkOutput("reset_overrun", int'(overrun), 0);
    wait_clks(4);

    // Table-driven single frames, rx_ready held high.
    for (int v = 0; v < 6; v++) begin
      x0 = xfer_count;
      f0 = ferr_count;
      o0 = ovr_count;
      if (vecs[v].stop_bit) exp_q.push_back(vecs[v].data);
      applyStimulus(vecs[v].data, vecs[v].stop_bit, vecs[v].hold_low);
      wait_clks(24);
      checkOutput($sformatf("vec%0d_xfers", v), xfer_count - x0, vecs[v].exp_xfers);
      checkOutput($sformatf("vec%0d_frame_err", v), ferr_count - f0, vecs[v].exp_ferr);
      checkOutput($sformatf("vec%0d_overrun", v), ovr_count - o0, vecs[v].exp_ovr);
    end

    // Back-to-back frames with no idle gap.
    x0 = xfer_count;
    f0 = ferr_count;
    o0 = ovr_count;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    applyStimulus(8'h00, 1'b1, 0);
    applyStimulus(8'hFF, 1'b1, 0);
    wait_clks(24);
    checkOutput("b2b_xfers", xfer_count - x0, 2);
    checkOutput("b2b_flags", (ferr_count - f0) + (ovr_count - o0), 0);

    // Short low glitch, then a real frame to show the FSM returned to idle.
    x0 = xfer_count;
    f0 = ferr_count;
    o0 = ovr_count;
    rxd = 1'b0;
    wait_clks(3);
    rxd = 1'b1;
    wait_clks(30);
    checkOutput("glitch_xfers", xfer_count - x0, 0);
    checkOutput("glitch_flags", (ferr_count - f0) + (ovr_count - o0), 0);
    exp_q.push_back(8'h6B);
    applyStimulus(8'h6B, 1'b1, 0);
    wait_clks(24);
    checkOutput("post_glitch_xfers", xfer_count - x0, 1);

    // Overrun: consumer stalled across two frames.
    rx_ready = 1'b0;
    x0 = xfer_count;
    f0 = ferr_count;
    o0 = ovr_count;
    exp_q.push_back(8'h12);
    applyStimulus(8'h12, 1'b1, 0);
    applyStimulus(8'h34, 1'b1, 0);
    wait_clks(24);
    checkOutput("ovr_overrun", ovr_count - o0, 1);
    checkOutput("ovr_frame_err", ferr_count - f0, 0);
    @(negedge clk);
    checkOutput("ovr_rx_data_held", int'(rx_data), 8'h12);
    checkOutput("ovr_rx_valid_held", int'(rx_valid), 1);
    @(posedge clk);
    #1;
    rx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("ovr_rx_valid_falls", int'(rx_valid), 0);
    checkOutput("ovr_xfers", xfer_count - x0, 1);
    wait_clks(8);

    // Reset during data bit 4; remaining line stays idle-high.
    frame6 = 8'hF3;
    x0 = xfer_count;
    rxd = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      rxd = frame6[i];
      wait_clks(BIT_CLKS);
    end
    rxd = frame6[4];
    wait_clks(BIT_CLKS / 2);
    rst_n = 1'b0;
    wait_clks(1);
    rst_n = 1'b1;
    rxd   = 1'b1;
    @(negedge clk);
    checkOutput("midreset_rx_data", int'(rx_data), 0);
    checkOutput("midreset_rx_valid", int'(rx_valid), 0);
    checkOutput("midreset_frame_err", int'(frame_err), 0);
    checkOutput("midreset_overrun", int'(overrun), 0);
    wait_clks(60);
    checkOutput("midreset_no_xfer", xfer_count - x0, 0);
    exp_q.push_back(8'h5A);
    applyStimulus(8'h5A, 1'b1, 0);
    wait_clks(24);
    checkOutput("after_reset_xfers", xfer_count - x0, 1);

    checkOutput("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
